jtag_debug_cmd_sysclk: RTL and testbench

System-clock half of the next-generation OCI debug JTAG bridge. It resynchronises virtual-JTAG update strobes (vs_uir, vs_udr) from the tck domain and latches the instruction register on each UIR. On each UDR it captures the scan register into a show-ahead command FIFO. Each command is presented to the debug core with a valid/ready handshake and decoded into per-instruction action/no-action strobes. Width, IR size, sync depth and FIFO depth are parametrised, replacing the fixed 38-bit/2-bit single-shot capture.

---
 rtl/jtag_debug_cmd_sysclk.sv | 128 ++++++++++++
 tb/tb_jtag_debug_cmd_sysclk.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_sysclk.sv
// System-clock half of the OCI debug JTAG bridge: resynchronises the virtual-JTAG
// update strobes, queues captured scans in a show-ahead FIFO and decodes pops into per-IR strobes.
module jtag_debug_cmd_sysclk #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACT_BIT     = 34
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [IR_WIDTH-1:0]            ir_in,
  input  logic [SR_WIDTH-1:0]            sr,
  input  logic                           vs_uir,
  input  logic                           vs_udr,
  input  logic                           cmd_ready,
  input  logic                           ovf_clr,
  output logic                           cmd_valid,
  output logic [IR_WIDTH-1:0]            cmd_ir,
  output logic [SR_WIDTH-1:0]            cmd_jdo,
  output logic [$clog2(FIFO_DEPTH):0]    cmd_count,
  output logic                           overflow,
  output logic [IR_WIDTH-1:0]            ir_cur,
  output logic [(2**IR_WIDTH)-1:0]       take_action,
  output logic [(2**IR_WIDTH)-1:0]       take_no_action
);

  localparam int NCH    = 2**IR_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam int ENT_W  = IR_WIDTH + SR_WIDTH;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync;
  logic                   r_uir_prev, r_udr_prev;
  logic                   r_uir_armed, r_udr_armed;
  logic [FILL_W-1:0]      r_fill;
  logic [IR_WIDTH-1:0]    r_ir_cur;
  logic                   w_filled, w_uir_lvl, w_udr_lvl, w_uir_rise, w_udr_rise;

  logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr, r_rptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;
  logic [NCH-1:0]         r_act, r_noact;
  logic                   w_full, w_pop, w_push, w_drop;
  logic [ENT_W-1:0]       w_head;
  logic [IR_WIDTH-1:0]    w_head_ir;
  logic [NCH-1:0]         w_sel;

  // The level is only trusted once the chain holds post-reset samples; a strobe
  // must then be seen low before its first rise counts.
  assign w_filled   = (r_fill == FILL_DONE);
  assign w_uir_lvl  = r_uir_sync[SYNC_STAGES-1];
  assign w_udr_lvl  = r_udr_sync[SYNC_STAGES-1];
  assign w_uir_rise = r_uir_armed & w_uir_lvl & ~r_uir_prev;
  assign w_udr_rise = r_udr_armed & w_udr_lvl & ~r_udr_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uir_sync  <= '0;
      r_udr_sync  <= '0;
      r_uir_prev  <= 1'b0;
      r_udr_prev  <= 1'b0;
      r_uir_armed <= 1'b0;
      r_udr_armed <= 1'b0;
      r_fill      <= '0;
      r_ir_cur    <= '0;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_prev <= w_uir_lvl;
      r_udr_prev <= w_udr_lvl;
      if (!w_filled) r_fill <= r_fill + FILL_W'(1);
      if (w_filled && !w_uir_lvl) r_uir_armed <= 1'b1;
      if (w_filled && !w_udr_lvl) r_udr_armed <= 1'b1;
      if (w_uir_rise) r_ir_cur <= ir_in;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = (r_count != '0) & cmd_ready;
  assign w_push    = w_udr_rise & (~w_full | w_pop);
  assign w_drop    = w_udr_rise & w_full & ~w_pop;
  assign w_head    = r_mem[r_rptr];
  assign w_head_ir = w_head[ENT_W-1:SR_WIDTH];
  assign w_sel     = NCH'(1) << w_head_ir;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_ir_cur, sr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_act      <= '0;
      r_noact    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
      r_act   <= (w_pop &&  w_head[ACT_BIT]) ? w_sel : '0;
      r_noact <= (w_pop && !w_head[ACT_BIT]) ? w_sel : '0;
    end
  end

  assign cmd_valid      = (r_count != '0);
  assign cmd_ir         = w_head_ir;
  assign cmd_jdo        = w_head[SR_WIDTH-1:0];
  assign cmd_count      = r_count;
  assign overflow       = r_overflow;
  assign ir_cur         = r_ir_cur;
  assign take_action    = r_act;
  assign take_no_action = r_noact;

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk.sv
// Bench for jtag_debug_cmd_sysclk: directed vector table, hand sequences for
// reset/overflow/full corners, and random traffic against a queue-based reference model.
module tb_jtag_debug_cmd_sysclk;

  localparam int SRW  = 38;
  localparam int IRW  = 2;
  localparam int SYN  = 2;
  localparam int DEP  = 4;
  localparam int ACTB = 34;
  localparam int NCH  = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [IRW-1:0] ir_in = '0;
  logic [SRW-1:0] sr = '0;
  logic           vs_uir = 1'b0;
  logic           vs_udr = 1'b0;
  logic           cmd_ready = 1'b0;
  logic           ovf_clr = 1'b0;
  logic           cmd_valid;
  logic [IRW-1:0] cmd_ir;
  logic [SRW-1:0] cmd_jdo;
  logic [2:0]     cmd_count;
  logic           overflow;
  logic [IRW-1:0] ir_cur;
  logic [NCH-1:0] take_action;
  logic [NCH-1:0] take_no_action;

  always #5 clk = ~clk;

  jtag_debug_cmd_sysclk #(
    .SR_WIDTH(SRW), .IR_WIDTH(IRW), .SYNC_STAGES(SYN), .FIFO_DEPTH(DEP), .ACT_BIT(ACTB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_jdo(cmd_jdo), .cmd_count(cmd_count),
    .overflow(overflow), .ir_cur(ir_cur),
    .take_action(take_action), .take_no_action(take_no_action)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: commands as a queue, strobe levels as sample histories
  // (newest first, -1 = no post-reset sample yet).
  typedef struct packed {
    logic [IRW-1:0] ir;
    logic [SRW-1:0] jdo;
  } ent_t;

  ent_t           mq[$];
  int             uh[$];
  int             dh[$];
  logic [IRW-1:0] m_ir;
  logic           m_ovf;
  logic [NCH-1:0] m_act, m_noact;

  function automatic void model_reset();
    mq.delete();
    uh.delete();
    dh.delete();
    for (int i = 0; i < SYN + 2; i++) begin
      uh.push_back(-1);
      dh.push_back(-1);
    end
    m_ir = '0;
    m_ovf = 1'b0;
    m_act = '0;
    m_noact = '0;
  endfunction

  // One clock edge: an update event happens SYN edges after the first high
  // sample that follows a real low sample.
  function automatic void model_edge(input logic uir, input logic udr, input logic [IRW-1:0] ir,
                                     input logic [SRW-1:0] s, input logic rdy, input logic clr);
    bit   uev, dev, drop;
    ent_t h;
    uh.push_front(int'(uir));
    dh.push_front(int'(udr));
    void'(uh.pop_back());
    void'(dh.pop_back());
    uev = (uh[SYN] == 1) && (uh[SYN+1] == 0);
    dev = (dh[SYN] == 1) && (dh[SYN+1] == 0);
    drop = 1'b0;
    m_act = '0;
    m_noact = '0;
    if (rdy && mq.size() > 0) begin
      h = mq.pop_front();
      if (h.jdo[ACTB]) m_act[h.ir] = 1'b1;
      else             m_noact[h.ir] = 1'b1;
    end
    if (dev) begin
      if (mq.size() < DEP) mq.push_back({m_ir, s});
      else drop = 1'b1;
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (uev) m_ir = ir;
  endfunction

  function automatic void check_model();
    chk("m_valid", 64'(cmd_valid), 64'(mq.size() != 0));
    chk("m_count", 64'(cmd_count), 64'(mq.size()));
    chk("m_ovf", 64'(overflow), 64'(m_ovf));
    chk("m_ircur", 64'(ir_cur), 64'(m_ir));
    chk("m_act", 64'(take_action), 64'(m_act));
    chk("m_noact", 64'(take_no_action), 64'(m_noact));
    if (mq.size() != 0) begin
      chk("m_cmd_ir", 64'(cmd_ir), 64'(mq[0].ir));
      chk("m_cmd_jdo", 64'(cmd_jdo), 64'(mq[0].jdo));
    end
  endfunction

  // Called at a negedge: drive inputs for the next posedge, then check at the following negedge.
  task automatic step(input logic uir, input logic udr, input logic [IRW-1:0] ir,
                      input logic [SRW-1:0] s, input logic rdy, input logic clr);
    vs_uir = uir;
    vs_udr = udr;
    ir_in = ir;
    sr = s;
    cmd_ready = rdy;
    ovf_clr = clr;
    model_edge(uir, udr, ir, s, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic push_sr(input logic [SRW-1:0] s, input logic rdy, input logic clr_at_push);
    step(1'b0, 1'b1, '0, s, rdy, 1'b0);
    step(1'b0, 1'b0, '0, s, rdy, 1'b0);
    step(1'b0, 1'b0, '0, s, rdy, clr_at_push);
  endtask

  task automatic apply_reset(input logic udr_level);
    reset_n = 1'b0;
    vs_uir = 1'b0;
    vs_udr = udr_level;
    cmd_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_count", 64'(cmd_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ircur", 64'(ir_cur), 64'd0);
    chk("rst_act", 64'(take_action), 64'd0);
    chk("rst_noact", 64'(take_no_action), 64'd0);
    model_reset();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic           uir, udr;
    logic [IRW-1:0] ir;
    logic [SRW-1:0] s;
    logic           rdy;
    logic           v;
    logic [2:0]     cnt;
    logic [IRW-1:0] icur, cir;
    logic [SRW-1:0] jdo;
    logic [NCH-1:0] act, noact;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input int uir, input int udr, input int ir, input logic [SRW-1:0] s,
                               input int rdy, input int v, input int cnt, input int icur,
                               input int cir, input logic [SRW-1:0] jdo, input int act, input int noact);
    vec_t r;
    r.uir = 1'(uir);   r.udr = 1'(udr);   r.ir = IRW'(ir);   r.s = s;
    r.rdy = 1'(rdy);   r.v = 1'(v);       r.cnt = 3'(cnt);   r.icur = IRW'(icur);
    r.cir = IRW'(cir); r.jdo = jdo;       r.act = NCH'(act); r.noact = NCH'(noact);
    return r;
  endfunction

  initial begin
    //              uir udr ir  sr               rdy  v cnt icur cir jdo              act     noact
    tbl.push_back(mkv(1, 0, 1, 38'h0,            0,   0, 0, 0,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 1, 38'h0,            0,   0, 0, 0,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 1, 38'h0,            0,   0, 0, 1,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 1, 0, 38'h2_0000_0ABC,  0,   0, 0, 1,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 0, 38'h2_0000_0ABC,  0,   0, 0, 1,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 0, 38'h2_0000_0ABC,  0,   1, 1, 1,   1, 38'h2_0000_0ABC,  0,      0));
    tbl.push_back(mkv(0, 0, 0, 38'h0,            1,   0, 0, 1,   0, 38'h0,            0,      4'b0010));
    tbl.push_back(mkv(0, 0, 0, 38'h0,            1,   0, 0, 1,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(1, 0, 3, 38'h0,            0,   0, 0, 1,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 3, 38'h0,            0,   0, 0, 1,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 3, 38'h0,            0,   0, 0, 3,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 1, 0, 38'h4_0000_0000,  0,   0, 0, 3,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 0, 38'h4_0000_0000,  0,   0, 0, 3,   0, 38'h0,            0,      0));
    tbl.push_back(mkv(0, 0, 0, 38'h4_0000_0000,  0,   1, 1, 3,   3, 38'h4_0000_0000,  0,      0));
    tbl.push_back(mkv(0, 0, 0, 38'h0,            1,   0, 0, 3,   0, 38'h0,            4'b1000, 0));
    tbl.push_back(mkv(0, 0, 0, 38'h0,            1,   0, 0, 3,   0, 38'h0,            0,      0));

    // vs_udr held high across reset release must not create a command
    @(negedge clk);
    apply_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      chk("held_no_push", 64'(cmd_valid), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("held_low_no_push", 64'(cmd_valid), 64'd0);
    end
    push_sr(38'h55, 1'b0, 1'b0);
    chk("one_push_count", 64'(cmd_count), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("no_phantom_count", 64'(cmd_count), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("one_push_drained", 64'(cmd_count), 64'd0);
    chk("one_push_noact", 64'(take_no_action), 64'd1);

    // Directed vectors: latency, IR capture, action/no-action decode
    foreach (tbl[i]) begin
      step(tbl[i].uir, tbl[i].udr, tbl[i].ir, tbl[i].s, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 64'(cmd_valid), 64'(tbl[i].v));
      chk($sformatf("tbl%0d_count", i), 64'(cmd_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ircur", i), 64'(ir_cur), 64'(tbl[i].icur));
      chk($sformatf("tbl%0d_act", i), 64'(take_action), 64'(tbl[i].act));
      chk($sformatf("tbl%0d_noact", i), 64'(take_no_action), 64'(tbl[i].noact));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_cmd_ir", i), 64'(cmd_ir), 64'(tbl[i].cir));
        chk($sformatf("tbl%0d_cmd_jdo", i), 64'(cmd_jdo), 64'(tbl[i].jdo));
      end
    end

    // Overflow: fifth push dropped; ovf_clr on the same edge loses to the set
    for (int i = 1; i <= 5; i++) push_sr(SRW'(i), 1'b0, i == 5);
    chk("ovf_count", 64'(cmd_count), 64'd4);
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), 64'(cmd_jdo), 64'(i));
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("ovf_drained", 64'(cmd_count), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Full FIFO with pop on the push edge: both happen, no overflow
    for (int i = 10; i <= 13; i++) push_sr(SRW'(i), 1'b0, 1'b0);
    chk("full_count", 64'(cmd_count), 64'd4);
    step(1'b0, 1'b1, '0, 38'd14, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 38'd14, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 38'd14, 1'b1, 1'b0);
    chk("fullpp_count", 64'(cmd_count), 64'd4);
    chk("fullpp_ovf", 64'(overflow), 64'd0);
    for (int i = 11; i <= 14; i++) begin
      chk($sformatf("fullpp_drain%0d", i), 64'(cmd_jdo), 64'(i));
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("fullpp_empty", 64'(cmd_valid), 64'd0);

    // Asynchronous reset with three commands queued
    for (int i = 21; i <= 23; i++) push_sr(SRW'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 64'(cmd_count), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(cmd_count), 64'd0);
    chk("async_rst_valid", 64'(cmd_valid), 64'd0);
    chk("async_rst_ircur", 64'(ir_cur), 64'd0);
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk("post_rst_act", 64'(take_action), 64'd0);
      chk("post_rst_noact", 64'(take_no_action), 64'd0);
      chk("post_rst_valid", 64'(cmd_valid), 64'd0);
    end

    // Random traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, IRW'($urandom),
           {6'($urandom), 32'($urandom)}, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
